// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter in front of a single main memory.
// Each granted transaction runs IDLE -> ACCESS (MEM_LATENCY cycles) -> DONE -> RELEASE.
module bus_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic       CC_clk,
  input  logic       rst,
  input  logic       bus_access_0,
  input  logic       bus_access_1,
  input  logic       write_opn_to_bus_0,
  input  logic       write_opn_to_bus_1,
  input  logic [7:0] read_select_Mem_0,
  input  logic [7:0] read_select_Mem_1,
  input  logic [7:0] write_select_Mem_0,
  input  logic [7:0] write_select_Mem_1,
  input  logic [7:0] write_data_Mem_0,
  input  logic [7:0] write_data_Mem_1,
  input  logic [7:0] out_data_Mem,
  output logic [7:0] mem_read_addr,
  output logic [7:0] mem_write_addr,
  output logic [7:0] mem_write_data,
  output logic       mem_write_enable,
  output logic       finish_0,
  output logic       finish_1,
  output logic [7:0] out_data_Mem_0,
  output logic [7:0] out_data_Mem_1,
  output logic       flag_snoop_0,
  output logic       flag_snoop_1,
  output logic [7:0] snoop_address
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       gnt_q, gnt_d;
  logic       wr_q, wr_d;
  logic [7:0] raddr_q, raddr_d, waddr_q, waddr_d, wdata_q, wdata_d, snpa_q, snpa_d;
  logic       we_q, we_d, fin0_q, fin0_d, fin1_q, fin1_d, snp0_q, snp0_d, snp1_q, snp1_d;
  logic [7:0] od0_q, od0_d, od1_q, od1_d;
  logic       sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    snpa_d  = snpa_q;
    we_d    = 1'b0;
    fin0_d  = 1'b0;
    fin1_d  = 1'b0;
    snp0_d  = 1'b0;
    snp1_d  = 1'b0;
    od0_d   = 8'h00;
    od1_d   = 8'h00;
    sel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_access_0 || bus_access_1) begin
          // On a tie the master that was not granted last wins.
          sel     = (bus_access_0 && bus_access_1) ? ~last_q : bus_access_1;
          gnt_d   = sel;
          last_d  = sel;
          wr_d    = sel ? write_opn_to_bus_1 : write_opn_to_bus_0;
          raddr_d = sel ? read_select_Mem_1  : read_select_Mem_0;
          waddr_d = sel ? write_select_Mem_1 : write_select_Mem_0;
          wdata_d = sel ? write_data_Mem_1   : write_data_Mem_0;
          cnt_d   = 4'(MEM_LATENCY - 1);
          state_d = ACCESS;
          // Write strobe and snoop of the other master fire in the first access cycle.
          we_d    = wr_d;
          snp0_d  = wr_d & sel;
          snp1_d  = wr_d & ~sel;
          if (wr_d) snpa_d = waddr_d;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          fin0_d  = ~gnt_q;
          fin1_d  = gnt_q;
          od0_d   = (~gnt_q && !wr_q) ? out_data_Mem : 8'h00;
          od1_d   = ( gnt_q && !wr_q) ? out_data_Mem : 8'h00;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = RELEASE;
      RELEASE: if (!(gnt_q ? bus_access_1 : bus_access_0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CC_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      raddr_q <= 8'h00;
      waddr_q <= 8'h00;
      wdata_q <= 8'h00;
      snpa_q  <= 8'h00;
      we_q    <= 1'b0;
      fin0_q  <= 1'b0;
      fin1_q  <= 1'b0;
      snp0_q  <= 1'b0;
      snp1_q  <= 1'b0;
      od0_q   <= 8'h00;
      od1_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      snpa_q  <= snpa_d;
      we_q    <= we_d;
      fin0_q  <= fin0_d;
      fin1_q  <= fin1_d;
      snp0_q  <= snp0_d;
      snp1_q  <= snp1_d;
      od0_q   <= od0_d;
      od1_q   <= od1_d;
    end
  end

  assign mem_read_addr    = raddr_q;
  assign mem_write_addr   = waddr_q;
  assign mem_write_data   = wdata_q;
  assign mem_write_enable = we_q;
  assign finish_0         = fin0_q;
  assign finish_1         = fin1_q;
  assign out_data_Mem_0   = od0_q;
  assign out_data_Mem_1   = od1_q;
  assign flag_snoop_0     = snp0_q;
  assign flag_snoop_1     = snp1_q;
  assign snoop_address    = snpa_q;
endmodule
